// File: rtl/fft_bin_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fft_bin_scheduler                                             |
// | Purpose  : Frames the FFT output stream, forms per-bin scaled magnitude  |
// |            levels on one shared multiplier, publishes them atomically.   |
// | Options  : PEAK_HOLD_EN enables per-bin peak-hold with geometric decay.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fft_bin_scheduler #(
    parameter int WIDTH       = 12,
    parameter int BINS        = 8,
    parameter int BIN_DIV     = 7,
    parameter int DECAY_SHIFT = 3,
    parameter int LEVEL_W     = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      fft_ce,
    input  logic                      fft_sync,
    input  logic signed [WIDTH-1:0]   fft_real,
    input  logic signed [WIDTH-1:0]   fft_imag,
    input  logic                      frame_ack,
    output logic [BINS*LEVEL_W-1:0]   levels,
    output logic                      frame_valid,
    output logic [7:0]                overrun_cnt,
    output logic                      busy
);

    localparam int c_IDX_W = (BINS > 1) ? $clog2(BINS) : 1;
    localparam int c_ACC_W = 2 * WIDTH + 1;
    localparam logic [LEVEL_W-1:0] c_LEVEL_MAX = '1;
    localparam logic [c_IDX_W-1:0] c_LAST_BIN  = c_IDX_W'(BINS - 1);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_CAPTURE  = 3'd1;
    localparam logic [2:0] c_ST_COMPUTE  = 3'd2;
    localparam logic [2:0] c_ST_PUBLISH  = 3'd3;
    localparam logic [2:0] c_ST_WAIT_ACK = 3'd4;

    localparam logic [1:0] c_PH_A = 2'd0;
    localparam logic [1:0] c_PH_B = 2'd1;
    localparam logic [1:0] c_PH_C = 2'd2;

    logic [2:0]                r_state;
    logic [2:0]                w_next_state;
    logic signed [WIDTH-1:0]   r_cap_re [BINS];
    logic signed [WIDTH-1:0]   r_cap_im [BINS];
    logic [c_IDX_W-1:0]        r_idx;
    logic [c_IDX_W-1:0]        r_bin;
    logic [1:0]                r_phase;
    logic [c_ACC_W-1:0]        r_acc;
    logic [LEVEL_W-1:0]        r_hold [BINS];
    logic [BINS*LEVEL_W-1:0]   r_levels;
    logic [BINS*LEVEL_W-1:0]   w_hold_flat;
    logic [7:0]                r_overrun_cnt;

    logic                      w_frame_start;
    logic                      w_cap_en;
    logic [c_IDX_W-1:0]        w_cap_idx;
    logic signed [WIDTH-1:0]   w_mul_op;
    logic signed [2*WIDTH-1:0] w_mul_ext;
    logic signed [2*WIDTH-1:0] w_prod;
    logic [c_ACC_W-1:0]        w_scaled;
    logic [LEVEL_W-1:0]        w_sat;
    logic [LEVEL_W-1:0]        w_hold_next;

    assign w_frame_start = fft_ce && fft_sync;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:     if (w_frame_start) w_next_state = c_ST_CAPTURE;
            c_ST_CAPTURE:  if (fft_ce && !fft_sync && (r_idx == c_LAST_BIN)) w_next_state = c_ST_COMPUTE;
            c_ST_COMPUTE:  if ((r_phase == c_PH_C) && (r_bin == c_LAST_BIN)) w_next_state = c_ST_PUBLISH;
            c_ST_PUBLISH:  w_next_state = c_ST_WAIT_ACK;
            c_ST_WAIT_ACK: if (frame_ack) w_next_state = c_ST_IDLE;
            default:       w_next_state = c_ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        busy        = (r_state != c_ST_IDLE);
        frame_valid = (r_state == c_ST_WAIT_ACK);
    end

    // A sync outside IDLE either restarts a short frame or drops a whole one.
    assign w_cap_en  = fft_ce && (((r_state == c_ST_IDLE) && fft_sync) || (r_state == c_ST_CAPTURE));
    assign w_cap_idx = fft_sync ? '0 : r_idx;

    always_ff @(posedge clk) begin
        if (w_cap_en) begin
            r_cap_re[w_cap_idx] <= fft_real;
            r_cap_im[w_cap_idx] <= fft_imag;
        end
    end

    assign w_mul_op  = (r_phase == c_PH_A) ? r_cap_re[r_bin] : r_cap_im[r_bin];
    assign w_mul_ext = {{WIDTH{w_mul_op[WIDTH-1]}}, w_mul_op};
    assign w_prod    = w_mul_ext * w_mul_ext;
    assign w_scaled  = r_acc >> BIN_DIV;
    assign w_sat     = (w_scaled > c_ACC_W'(c_LEVEL_MAX)) ? c_LEVEL_MAX : w_scaled[LEVEL_W-1:0];

`ifdef PEAK_HOLD_EN
    logic [LEVEL_W-1:0] w_decayed;
    assign w_decayed   = r_hold[r_bin] - (r_hold[r_bin] >> DECAY_SHIFT);
    assign w_hold_next = (w_sat > w_decayed) ? w_sat : w_decayed;
`else
    logic w_unused_decay;
    assign w_unused_decay = |DECAY_SHIFT;
    assign w_hold_next    = w_sat;
`endif

    for (genvar k = 0; k < BINS; k++) begin : g_pack
        assign w_hold_flat[k*LEVEL_W +: LEVEL_W] = r_hold[k];
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_idx         <= '0;
            r_bin         <= '0;
            r_phase       <= c_PH_A;
            r_acc         <= '0;
            r_levels      <= '0;
            r_overrun_cnt <= '0;
            for (int k = 0; k < BINS; k++) r_hold[k] <= '0;
        end else begin
            if (w_frame_start && (r_state != c_ST_IDLE) && (r_overrun_cnt != 8'hFF))
                r_overrun_cnt <= r_overrun_cnt + 8'd1;

            case (r_state)
                c_ST_IDLE: begin
                    r_bin   <= '0;
                    r_phase <= c_PH_A;
                    if (w_frame_start) r_idx <= c_IDX_W'(1);
                end
                c_ST_CAPTURE: begin
                    if (w_frame_start)
                        r_idx <= c_IDX_W'(1);
                    else if (fft_ce)
                        r_idx <= (r_idx == c_LAST_BIN) ? '0 : r_idx + c_IDX_W'(1);
                end
                c_ST_COMPUTE: begin
                    case (r_phase)
                        c_PH_A: begin
                            r_acc   <= {1'b0, w_prod};
                            r_phase <= c_PH_B;
                        end
                        c_PH_B: begin
                            r_acc   <= r_acc + {1'b0, w_prod};
                            r_phase <= c_PH_C;
                        end
                        default: begin
                            r_hold[r_bin] <= w_hold_next;
                            r_phase       <= c_PH_A;
                            r_bin         <= (r_bin == c_LAST_BIN) ? '0 : r_bin + c_IDX_W'(1);
                        end
                    endcase
                end
                c_ST_PUBLISH: r_levels <= w_hold_flat;
                default: ;
            endcase
        end
    end

    assign levels      = r_levels;
    assign overrun_cnt = r_overrun_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fft_bin_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fft_bin_scheduler                                          |
// | Purpose  : Self-checking bench for fft_bin_scheduler against a           |
// |            frame-level magnitude/peak-hold reference model.              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fft_bin_scheduler;

    localparam int WIDTH       = 12;
    localparam int BINS        = 8;
    localparam int BIN_DIV     = 7;
    localparam int DECAY_SHIFT = 3;
    localparam int LEVEL_W     = 8;
    localparam int LATENCY     = 3 * BINS + 1;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic                      fft_ce;
    logic                      fft_sync;
    logic signed [WIDTH-1:0]   fft_real;
    logic signed [WIDTH-1:0]   fft_imag;
    logic                      frame_ack;
    logic [BINS*LEVEL_W-1:0]   levels;
    logic                      frame_valid;
    logic [7:0]                overrun_cnt;
    logic                      busy;

    int checks   = 0;
    int failures = 0;
    int fr_re [BINS];
    int fr_im [BINS];
    int exp_hold [BINS];
    int exp_overrun = 0;
    int exp_decay [3];

    always #5 clk = ~clk;

    fft_bin_scheduler #(
        .WIDTH(WIDTH), .BINS(BINS), .BIN_DIV(BIN_DIV),
        .DECAY_SHIFT(DECAY_SHIFT), .LEVEL_W(LEVEL_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .fft_ce(fft_ce), .fft_sync(fft_sync),
        .fft_real(fft_real), .fft_imag(fft_imag), .frame_ack(frame_ack),
        .levels(levels), .frame_valid(frame_valid),
        .overrun_cnt(overrun_cnt), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Reference: level = min(|X|^2 / 2^BIN_DIV, full scale), optional peak-hold.
    task automatic model_frame();
        int p, s, d;
        for (int k = 0; k < BINS; k++) begin
            p = fr_re[k] * fr_re[k] + fr_im[k] * fr_im[k];
            s = p / (1 << BIN_DIV);
            if (s > (1 << LEVEL_W) - 1) s = (1 << LEVEL_W) - 1;
`ifdef PEAK_HOLD_EN
            d = exp_hold[k] - exp_hold[k] / (1 << DECAY_SHIFT);
            exp_hold[k] = (s > d) ? s : d;
`else
            d = 0;
            exp_hold[k] = s + d;
`endif
        end
    endtask

    task automatic zero_frame();
        for (int k = 0; k < BINS; k++) begin
            fr_re[k] = 0;
            fr_im[k] = 0;
        end
    endtask

    task automatic rand_frame();
        for (int k = 0; k < BINS; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                fr_re[k] = int'($urandom_range(0, 360)) - 180;
                fr_im[k] = int'($urandom_range(0, 360)) - 180;
            end else begin
                fr_re[k] = int'($urandom_range(0, 4095)) - 2048;
                fr_im[k] = int'($urandom_range(0, 4095)) - 2048;
            end
        end
    endtask

    task automatic drive_sample(input int re, input int im, input bit sync);
        fft_ce   = 1'b1;
        fft_sync = sync;
        fft_real = WIDTH'(re);
        fft_imag = WIDTH'(im);
        @(posedge clk); #1;
        fft_ce   = 1'b0;
        fft_sync = 1'b0;
    endtask

    // Strobe-low cycles carry junk data and sync that must be ignored.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            fft_ce   = 1'b0;
            fft_sync = 1'($urandom_range(0, 1));
            fft_real = WIDTH'($urandom);
            fft_imag = WIDTH'($urandom);
            @(posedge clk); #1;
        end
        fft_sync = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        for (int k = 0; k < BINS; k++) begin
            if (gaps) idle_cycles(int'($urandom_range(0, 2)));
            drive_sample(fr_re[k], fr_im[k], k == 0);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (frame_valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, LATENCY);
    endtask

    task automatic check_levels(input string tag);
        for (int k = 0; k < BINS; k++)
            chk($sformatf("%s_bin%0d", tag, k), levels[k*LEVEL_W +: LEVEL_W], exp_hold[k]);
        chk({tag, "_overrun"}, overrun_cnt, exp_overrun);
    endtask

    task automatic finish_tied(input string tag);
        @(posedge clk); #1;
        chk({tag, "_pulse_end"}, frame_valid, 0);
        chk({tag, "_busy_end"}, busy, 0);
    endtask

    task automatic ack_now(input string tag);
        frame_ack = 1'b1;
        @(posedge clk); #1;
        frame_ack = 1'b0;
        chk({tag, "_valid_after_ack"}, frame_valid, 0);
        chk({tag, "_busy_after_ack"}, busy, 0);
    endtask

    task automatic full_frame_tied(input string tag, input bit gaps);
        frame_ack = 1'b1;
        send_frame(gaps);
        model_frame();
        wait_valid(tag);
        check_levels(tag);
        finish_tied(tag);
        frame_ack = 1'b0;
    endtask

    initial begin
        logic [BINS*LEVEL_W-1:0] held;
        int delay;
        bit seen;

`ifdef PEAK_HOLD_EN
        exp_decay[0] = 224; exp_decay[1] = 196; exp_decay[2] = 172;
`else
        exp_decay[0] = 0;   exp_decay[1] = 0;   exp_decay[2] = 0;
`endif
        for (int k = 0; k < BINS; k++) exp_hold[k] = 0;

        reset_n = 1'b0; fft_ce = 1'b0; fft_sync = 1'b0;
        fft_real = '0; fft_imag = '0; frame_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_levels", levels, 0);
        chk("reset_valid", frame_valid, 0);
        chk("reset_overrun", overrun_cnt, 0);
        chk("reset_busy", busy, 0);
        reset_n = 1'b1;
        idle_cycles(2);

        // Single tone in bin 0, ack tied high.
        zero_frame();
        fr_re[0] = 100;
        full_frame_tied("basic", 1'b0);
        chk("basic_bin0_const", levels[LEVEL_W-1:0], 78);

        // Full-scale negative input saturates.
        zero_frame();
        fr_re[3] = -2048; fr_im[3] = -2048;
        full_frame_tied("sat", 1'b1);
        chk("sat_bin3_const", levels[3*LEVEL_W +: LEVEL_W], 255);

        // Peak decay on bin 0.
        zero_frame();
        fr_re[0] = 2047;
        full_frame_tied("peak", 1'b0);
        for (int f = 0; f < 3; f++) begin
            zero_frame();
            full_frame_tied($sformatf("decay%0d", f), 1'b1);
            chk($sformatf("decay%0d_bin0_const", f), levels[LEVEL_W-1:0], exp_decay[f]);
        end

        // Held-off ack with a dropped frame during the wait.
        rand_frame();
        frame_ack = 1'b0;
        send_frame(1'b1);
        model_frame();
        wait_valid("hs");
        check_levels("hs");
        held = levels;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            fft_ce   = (i == 20);
            fft_sync = (i == 20);
            chk("hs_valid_hold", frame_valid, 1);
            chk("hs_levels_hold", levels, held);
        end
        fft_ce = 1'b0; fft_sync = 1'b0;
        exp_overrun++;
        chk("hs_overrun", overrun_cnt, exp_overrun);
        ack_now("hs");
        rand_frame();
        full_frame_tied("hs_next", 1'b1);

        // Short frame: restart on an early sync.
        drive_sample(int'($urandom_range(0, 4095)) - 2048, 555, 1'b1);
        drive_sample(1000, -1000, 1'b0);
        drive_sample(-700, 700, 1'b0);
        exp_overrun++;
        rand_frame();
        full_frame_tied("short", 1'b1);

        // Randomised frames with random ack delays.
        for (int f = 0; f < 6; f++) begin
            rand_frame();
            delay = int'($urandom_range(0, 5));
            frame_ack = (delay == 0);
            send_frame(1'b1);
            model_frame();
            wait_valid($sformatf("rnd%0d", f));
            check_levels($sformatf("rnd%0d", f));
            if (delay == 0) begin
                finish_tied($sformatf("rnd%0d", f));
                frame_ack = 1'b0;
            end else begin
                repeat (delay) @(posedge clk);
                #1;
                chk($sformatf("rnd%0d_valid_wait", f), frame_valid, 1);
                ack_now($sformatf("rnd%0d", f));
            end
        end

        // Reset during COMPUTE discards everything.
        rand_frame();
        frame_ack = 1'b1;
        send_frame(1'b0);
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("midrst_levels", levels, 0);
        chk("midrst_valid", frame_valid, 0);
        chk("midrst_overrun", overrun_cnt, 0);
        chk("midrst_busy", busy, 0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (frame_valid === 1'b1) seen = 1'b1;
        end
        chk("midrst_no_publish", seen, 0);
        for (int k = 0; k < BINS; k++) exp_hold[k] = 0;
        exp_overrun = 0;
        rand_frame();
        full_frame_tied("after_rst", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_bin_scheduler.md
Name: fft_bin_scheduler

Overview:
Sequences the FFT output stream into the LED bin levels. The block frames on the FFT sync pulse and captures the first BINS complex outputs. It then computes each bin's magnitude-squared on one time-shared multiplier, scales and saturates the result, applies peak-hold decay, and publishes all levels atomically with a valid/ack handshake. It sits between the FFT core and the gamma-LUT/PWM stage.

Parameters:
WIDTH, 12, signed width of FFT real/imag outputs
BINS, 8, number of bins captured per frame (2..16)
BIN_DIV, 7, right shift applied to magnitude-squared before saturation
DECAY_SHIFT, 3, peak-hold decay: level loses level>>DECAY_SHIFT per frame
LEVEL_W, 8, width of each published level

Ports:
clk  in  1  system clock (single clock domain)
reset_n  in  1  synchronous active-low reset
fft_ce  in  1  FFT output strobe; real/imag/sync valid when high
fft_sync  in  1  with fft_ce, marks bin 0 of a frame
fft_real  in  WIDTH  signed real output
fft_imag  in  WIDTH  signed imaginary output
frame_ack  in  1  consumer accepts published levels
levels  out  BINS*LEVEL_W  flat level bus, bin k at [k*LEVEL_W +: LEVEL_W]
frame_valid  out  1  new levels published, held until acked
overrun_cnt  out  8  frames dropped, saturating
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset_n low at clk edge):
  - State goes to IDLE.
  - levels, peak-hold regs, frame_valid, overrun_cnt and the capture index all go to 0.
  - Reset mid-frame discards all partial capture and compute.
- Ignored inputs: fft_real/fft_imag/fft_sync are ignored when fft_ce is low.
- IDLE:
  - Waits for fft_ce && fft_sync.
  - On that cycle, captures bin 0 into cap_re[0]/cap_im[0], sets idx=1, goes to CAPTURE.
- CAPTURE:
  - Each fft_ce stores inputs into cap[idx], then idx++.
  - After cap[BINS-1] is stored, goes to COMPUTE.
  - If fft_ce && fft_sync arrives before BINS samples: restart the capture at bin 0 with that sample, and increment overrun_cnt.
- COMPUTE: three cycles per bin k = 0..BINS-1, using one shared WIDTH x WIDTH signed multiplier.
  - Phase A: acc = re*re.
  - Phase B: acc = acc + im*im. acc is 2*WIDTH+1 bits unsigned; (-2048)^2 + (-2048)^2 = 8388608 fits.
  - Phase C: s = acc >> BIN_DIV, then sat = (s > 2^LEVEL_W-1) ? 2^LEVEL_W-1 : s. Update hold[k] (see Optional Feature).
  - After bin BINS-1 phase C, goes to PUBLISH. Total 3*BINS cycles.
- PUBLISH: one cycle. Copies all hold[] to levels at once, sets frame_valid=1, goes to WAIT_ACK.
  - Latency: frame_valid rises 3*BINS+1 clk edges after the edge that captured the last bin (25 for BINS=8).
- WAIT_ACK:
  - frame_valid stays high and levels stay stable until a cycle with frame_ack high.
  - That edge clears frame_valid and returns to IDLE.
  - frame_ack high in the first cycle frame_valid is seen counts as the ack. frame_ack tied high gives a one-cycle pulse.
- Frame during COMPUTE/PUBLISH/WAIT_ACK: fft_ce && fft_sync in these states increments overrun_cnt (saturates at 255) and that frame is not captured. The block resumes capturing on the next sync after reaching IDLE.
- Stable outputs: levels change only in PUBLISH.

Optional Feature:
Macro PEAK_HOLD_EN.
- Defined:
  - decayed = hold[k] - (hold[k] >> DECAY_SHIFT).
  - hold[k] = max(sat, decayed).
- Undefined: hold[k] = sat. DECAY_SHIFT is unused.
- Timing and handshake are identical in both builds.

Test Plan:
- Reset, then sync frame: bin0 real=100 imag=0, other bins 0, frame_ack tied high.
  - frame_valid pulses one cycle, 25 cycles after the last capture.
  - levels bin0 = 10000>>7 = 78, other bins = 0.
  - busy=0 afterwards.
- Saturation: bin3 real=-2048 imag=-2048.
  - 8388608>>7 = 65536, so bin3 = 255. Other bins unaffected.
- Peak decay (PEAK_HOLD_EN): frame with bin0=255, then frames with bin0 input 0.
  - Successive bin0 levels: 224, 196, 172.
  - Without the macro: bin0 = 0 on the second frame.
- Handshake: frame_ack held low 40 cycles after frame_valid.
  - levels and frame_valid stay stable.
  - A sync during the wait gives overrun_cnt=1.
  - Ack returns to IDLE; the next sync is captured.
- Short frame: sync, 3 samples, sync again.
  - overrun_cnt=1; capture restarts; the published frame uses samples after the second sync.
- Reset mid-COMPUTE: reset_n low one cycle at COMPUTE cycle 10.
  - levels=0, frame_valid=0, overrun_cnt=0.
  - No publish until the next full frame.
